// File: rtl/dmem_responder_if.sv
// MEM-stage data-memory bus between the pipeline (master) and dmem_responder (slave).
interface dmem_responder_if;
  logic        i_stb;
  logic        i_wr_en;
  logic [31:0] i_addr;
  logic [31:0] i_wr_data;
  logic [1:0]  i_wr_size;
  logic        o_rd_ack;
  logic [31:0] o_read_data;
  logic        o_err;

  modport master (
    output i_stb, i_wr_en, i_addr, i_wr_data, i_wr_size,
    input  o_rd_ack, o_read_data, o_err
  );

  modport slave (
    input  i_stb, i_wr_en, i_addr, i_wr_data, i_wr_size,
    output o_rd_ack, o_read_data, o_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Single-port data memory: multi-cycle loads that stall via o_rd_ack, single-cycle
// byte/half/word stores, registered error pulse on misaligned or out-of-range access.
module dmem_responder #(
  parameter int DEPTH_WORDS  = 1024,
  parameter int READ_LATENCY = 2
) (
  input  logic            clk,
  input  logic            rst,
  dmem_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  logic [31:0]   r_mem [DEPTH_WORDS];
  state_t        r_state, w_state_nxt;
  logic [3:0]    r_cnt, w_cnt_nxt;
  logic [31:0]   r_addr, w_addr_nxt;
  logic [31:0]   r_read_data;
  logic          r_err;

  logic [31:0]   w_ld_addr;
  logic          w_ld_oor;
  logic [AW-1:0] w_ld_idx;
  logic [31:0]   w_rd_word;
  logic          w_st_oor, w_st_mis, w_st_go;
  logic [AW-1:0] w_st_idx;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic          w_capture, w_err_nxt;

  // In IDLE the capture (READ_LATENCY=1) must see the live address, later the latched one.
  assign w_ld_addr = (r_state == S_IDLE) ? bus.i_addr : r_addr;
  assign w_ld_oor  = |w_ld_addr[31:AW+2];
  assign w_ld_idx  = w_ld_addr[AW+1:2];
  assign w_rd_word = w_ld_oor ? '0 : (r_mem[w_ld_idx] >> {w_ld_addr[1:0], 3'b000});

  assign w_st_oor = |bus.i_addr[31:AW+2];
  assign w_st_idx = bus.i_addr[AW+1:2];
  assign w_st_mis = ((bus.i_wr_size == 2'b01) && bus.i_addr[0]) ||
                    (bus.i_wr_size[1] && (bus.i_addr[1:0] != 2'b00));

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = bus.i_wr_data;
    case (bus.i_wr_size)
      2'b00: begin
        w_be    = 4'b0001 << bus.i_addr[1:0];
        w_wdata = {4{bus.i_wr_data[7:0]}};
      end
      2'b01: begin
        w_be    = bus.i_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{bus.i_wr_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_addr_nxt  = r_addr;
    w_capture   = 1'b0;
    w_err_nxt   = 1'b0;
    w_st_go     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.i_stb) begin
          w_addr_nxt = bus.i_addr;
          if (bus.i_wr_en) w_err_nxt = 1'b1;
          if (READ_LATENCY == 1) begin
            w_state_nxt = S_DONE;
            w_capture   = 1'b1;
            if (w_ld_oor) w_err_nxt = 1'b1;
          end else begin
            w_cnt_nxt   = 4'(READ_LATENCY - 1);
            w_state_nxt = S_WAIT;
          end
        end else if (bus.i_wr_en) begin
          if (w_st_mis || w_st_oor) w_err_nxt = 1'b1;
          else                      w_st_go   = 1'b1;
        end
      end
      S_WAIT: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt <= 4'd1) begin
          w_state_nxt = S_DONE;
          w_capture   = 1'b1;
          if (w_ld_oor) w_err_nxt = 1'b1;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_read_data <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_addr  <= w_addr_nxt;
      r_err   <= w_err_nxt;
      if (w_capture) r_read_data <= w_rd_word;
    end
  end

  // Array is deliberately outside the reset domain so contents survive rst.
  always_ff @(posedge clk) begin
    if (w_st_go) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_st_idx][8*b +: 8] <= w_wdata[8*b +: 8];
      end
    end
  end

  assign bus.o_rd_ack    = !rst && (((r_state == S_IDLE) && !bus.i_stb) || (r_state == S_DONE));
  assign bus.o_read_data = r_read_data;
  assign bus.o_err       = r_err;
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Single-port data memory that answers the MEM stage's data-memory requests (`stb`, `wr_en`, `addr`, `wr_data`, `rd_ack`, `read_data`).
- Reads complete after a parameterised latency; `o_rd_ack` is held low meanwhile, which stalls the pipeline.
- Stores complete in one cycle and never stall.
- Handles byte-lane placement for SB/SH/SW and flags misaligned or out-of-range accesses.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the array (power of two).
- READ_LATENCY, 2, cycles a load stalls the pipeline (legal range 1..15).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_stb  in  1  load request (level, held by the initiator until the ack).
- i_wr_en  in  1  store request (level).
- i_addr  in  32  byte address.
- i_wr_data  in  32  store data, zero-extended into the low bits.
- i_wr_size  in  2  store size: 00 byte, 01 half, 10/11 word (func3[1:0]).
- o_rd_ack  out  1  ready/ack; low means the initiator must stall.
- o_read_data  out  32  load data, addressed byte placed at [7:0].
- o_err  out  1  one-cycle pulse on an illegal access.

Behaviour:
- Reset (asynchronous, rst=1):
  - state=IDLE, counter=0.
  - o_rd_ack=0, o_read_data=0, o_err=0.
  - Array contents are not cleared.
  - Reset mid-load aborts the load; no data is returned.
- FSM states: IDLE, WAIT, DONE.
- o_rd_ack is combinational:
  - 1 in IDLE when i_stb=0.
  - 0 in IDLE when i_stb=1.
  - 0 in WAIT.
  - 1 in DONE.
- IDLE with i_stb=1:
  - Latch addr.
  - If READ_LATENCY=1, go to DONE.
  - Otherwise load counter=READ_LATENCY-1 and go to WAIT.
- WAIT: decrement the counter; when the counter reaches 1, go to DONE.
- Entering DONE: o_read_data registers (word[addr_word] >> 8*addr[1:0]).
- Load stall: ack is low for exactly READ_LATENCY cycles; ack=1 in the DONE cycle.
- DONE always returns to IDLE. If i_stb is still high in the next IDLE cycle, it is a new load and a new stall begins.
- o_read_data holds its value until the next DONE.
- Word index is i_addr[log2(DEPTH_WORDS)+1:2].
- Loads are never misaligned-checked: the initiator extracts the low bits, so the word is right-shifted by byte offset with zero fill.
- Store, accepted only in IDLE with i_wr_en=1 and i_stb=0:
  - Written on that clock edge; ack stays 1.
  - Byte: lane addr[1:0] ← wr_data[7:0].
  - Half: lanes {addr[1],0}..+1 ← wr_data[15:0].
  - Word: all lanes ← wr_data.
  - Other lanes are unchanged.
- Misaligned store: half with addr[0]=1, or word with addr[1:0]≠0.
  - Array unchanged.
  - o_err=1 for the next cycle (registered).
- Out of range: addr ≥ 4*DEPTH_WORDS.
  - Store: dropped, with an o_err pulse.
  - Load: still stalls READ_LATENCY cycles, returns 0, with an o_err pulse in the DONE cycle.
- i_stb and i_wr_en both 1 in IDLE:
  - Treated as a load.
  - The store is ignored.
  - o_err pulses one cycle later.
- i_wr_en in WAIT/DONE is ignored, with no error (this cannot occur while the pipeline is stalled).
- Read-after-write to the same word in consecutive cycles returns the new data, because the store edge precedes the capture into DONE.

Test Plan:
- Reset then idle → o_rd_ack=0 during rst; after release o_rd_ack=1, o_read_data=0, o_err=0.
- SW 0xDEADBEEF @0x10, then LW @0x10 (LATENCY=2) → ack low 2 cycles, then 1 with read_data=0xDEADBEEF; total 3 cycles from stb rise.
- SB 0x000000AA @0x11, then LW @0x10 → read_data=0xDEADAAEF; LB @0x13 → read_data=0x000000DE.
- SH 0x00001234 @0x12 → word=0x1234AAEF. SH @0x13 → word unchanged, o_err pulse 1 cycle.
- Back-to-back loads (stb held high across two loads, different addresses) → two separate stalls of READ_LATENCY cycles, each DONE returning the correct word.
- Load to 0x1000 with DEPTH_WORDS=1024 → returns 0 with an o_err pulse. Reset asserted in WAIT → immediate IDLE, ack=0 while rst=1, previously stored data intact afterwards.
